// File: rtl/udp_tx_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | udp_tx_arbiter_if                                                        |
// | UDP TX header + payload AXI-Stream bundle, N lanes packed per field.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface udp_tx_arbiter_if #(
  parameter int N = 1
);
  logic [N-1:0]    hdr_valid;
  logic [N-1:0]    hdr_ready;
  logic [32*N-1:0] ip_dest_ip;
  logic [16*N-1:0] source_port;
  logic [16*N-1:0] dest_port;
  logic [16*N-1:0] length;
  logic [8*N-1:0]  tdata;
  logic [N-1:0]    tvalid;
  logic [N-1:0]    tlast;
  logic [N-1:0]    tuser;
  logic [N-1:0]    tready;

  modport master (
    output hdr_valid, ip_dest_ip, source_port, dest_port, length,
    output tdata, tvalid, tlast, tuser,
    input  hdr_ready, tready
  );

  modport slave (
    input  hdr_valid, ip_dest_ip, source_port, dest_port, length,
    input  tdata, tvalid, tlast, tuser,
    output hdr_ready, tready
  );
endinterface
`default_nettype wire

// File: rtl/udp_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | udp_tx_arbiter                                                           |
// | Frame-granular round-robin arbiter of N UDP TX requesters onto one port. |
// | Optional payload watchdog: define UDP_TX_ARB_WATCHDOG_EN.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module udp_tx_arbiter #(
  parameter int N              = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic                            clk,
  input  wire logic                            reset,
  udp_tx_arbiter_if.slave                      s,
  udp_tx_arbiter_if.master                     m,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant,
  output logic                                 busy,
  output logic                                 abort
);

  localparam int C_GW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] C_ST_IDLE    = 3'd0;
  localparam logic [2:0] C_ST_HEADER  = 3'd1;
  localparam logic [2:0] C_ST_PAYLOAD = 3'd2;
`ifdef UDP_TX_ARB_WATCHDOG_EN
  localparam logic [2:0] C_ST_ABORT   = 3'd3;
  localparam logic [2:0] C_ST_DRAIN   = 3'd4;
  localparam logic [15:0] C_TIMEOUT   = 16'(TIMEOUT_CYCLES);
`endif

  logic [2:0]      r_state;
  logic [C_GW-1:0] r_ptr;
  logic [C_GW-1:0] r_grant;

  logic [C_GW-1:0] w_pick;
  logic            w_any;
  logic [C_GW-1:0] w_next;

  logic [31:0]     w_dest;
  logic [15:0]     w_sport;
  logic [15:0]     w_dport;
  logic [15:0]     w_len;
  logic [7:0]      w_tdata;
  logic            w_tvalid;
  logic            w_tlast;
  logic            w_tuser;

  logic            w_hdr_rdy;
  logic            w_t_rdy;
  logic            w_abort;

  // Round-robin scan starting at r_ptr; the first requester found wins.
  always_comb begin
    logic [C_GW-1:0] v_idx;
    w_pick = '0;
    w_any  = 1'b0;
    v_idx  = '0;
    for (int k = 0; k < N; k++) begin
      v_idx = C_GW'((int'(r_ptr) + k) % N);
      if (!w_any && s.hdr_valid[v_idx]) begin
        w_any  = 1'b1;
        w_pick = v_idx;
      end
    end
  end

  assign w_next = (r_grant == C_GW'(N - 1)) ? '0 : r_grant + 1'b1;

  assign w_dest   = s.ip_dest_ip[32*r_grant +: 32];
  assign w_sport  = s.source_port[16*r_grant +: 16];
  assign w_dport  = s.dest_port[16*r_grant +: 16];
  assign w_len    = s.length[16*r_grant +: 16];
  assign w_tdata  = s.tdata[8*r_grant +: 8];
  assign w_tvalid = s.tvalid[r_grant];
  assign w_tlast  = s.tlast[r_grant];
  assign w_tuser  = s.tuser[r_grant];

  always_comb begin
    m.hdr_valid   = 1'b0;
    m.ip_dest_ip  = '0;
    m.source_port = '0;
    m.dest_port   = '0;
    m.length      = '0;
    m.tdata       = '0;
    m.tvalid      = 1'b0;
    m.tlast       = 1'b0;
    m.tuser       = 1'b0;
    w_hdr_rdy     = 1'b0;
    w_t_rdy       = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      C_ST_HEADER: begin
        m.hdr_valid   = 1'b1;
        m.ip_dest_ip  = w_dest;
        m.source_port = w_sport;
        m.dest_port   = w_dport;
        m.length      = w_len;
        w_hdr_rdy     = m.hdr_ready;
      end
      C_ST_PAYLOAD: begin
        m.tdata  = w_tdata;
        m.tvalid = w_tvalid;
        m.tlast  = w_tlast;
        m.tuser  = w_tuser;
        w_t_rdy  = m.tready;
      end
`ifdef UDP_TX_ARB_WATCHDOG_EN
      // Synthetic errored tail beat closes the downstream frame.
      C_ST_ABORT: begin
        m.tvalid = 1'b1;
        m.tlast  = 1'b1;
        m.tuser  = 1'b1;
        w_abort  = m.tready;
      end
      C_ST_DRAIN: begin
        w_t_rdy = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Only the granted lane ever sees a ready.
  assign s.hdr_ready = {{(N-1){1'b0}}, w_hdr_rdy} << r_grant;
  assign s.tready    = {{(N-1){1'b0}}, w_t_rdy} << r_grant;

`ifdef UDP_TX_ARB_WATCHDOG_EN
  logic [15:0] r_wd_cnt;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^16'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= C_ST_IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
`ifdef UDP_TX_ARB_WATCHDOG_EN
      r_wd_cnt <= '0;
`endif
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= C_ST_HEADER;
          end
        end
        C_ST_HEADER: begin
          if (m.hdr_ready) begin
            r_state  <= C_ST_PAYLOAD;
`ifdef UDP_TX_ARB_WATCHDOG_EN
            r_wd_cnt <= '0;
`endif
          end
        end
        C_ST_PAYLOAD: begin
          if (w_tvalid && m.tready) begin
`ifdef UDP_TX_ARB_WATCHDOG_EN
            r_wd_cnt <= '0;
`endif
            if (w_tlast) begin
              r_ptr   <= w_next;
              r_state <= C_ST_IDLE;
            end
          end
`ifdef UDP_TX_ARB_WATCHDOG_EN
          // Only source starvation counts; downstream backpressure does not.
          else if (r_wd_cnt == C_TIMEOUT) begin
            r_state <= C_ST_ABORT;
          end else if (!w_tvalid) begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
          end
`endif
        end
`ifdef UDP_TX_ARB_WATCHDOG_EN
        C_ST_ABORT: begin
          if (m.tready) r_state <= C_ST_DRAIN;
        end
        C_ST_DRAIN: begin
          if (w_tvalid && w_tlast) begin
            r_ptr   <= w_next;
            r_state <= C_ST_IDLE;
          end
        end
`endif
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state != C_ST_IDLE);
  assign abort = w_abort;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_udp_tx_arbiter                                                        |
// | Directed self-checking bench for udp_tx_arbiter (N=4).                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_udp_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  udp_tx_arbiter_if #(.N(N)) s_if ();
  udp_tx_arbiter_if #(.N(1)) m_if ();
  logic [1:0] grant;
  logic       busy;
  logic       abort;

  udp_tx_arbiter #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (s_if),
    .m     (m_if),
    .grant (grant),
    .busy  (busy),
    .abort (abort)
  );

  // Source queues (driven), expected queues (scoreboard); payload entry = {tuser,tlast,tdata}
  logic [79:0] q_hdr [N][$];
  logic [9:0]  q_pay [N][$];
  logic [79:0] e_hdr [N][$];
  logic [9:0]  e_pay [N][$];
  int q_gr[$];
  int q_hcyc[$];
  int q_lcyc[$];
  int n_beats = 0;
  int n_abort = 0;
  int sb_err  = 0;
  int viol    = 0;
  int cyc     = 0;
  bit bp_rand = 1'b0;
  bit [N-1:0] stall = '0;
  int n_chk   = 0;
  int n_fail  = 0;

  task automatic drive_all();
    logic [79:0] h;
    logic [9:0]  p;
    for (int i = 0; i < N; i++) begin
      h = (q_hdr[i].size() > 0) ? q_hdr[i][0] : '0;
      p = (q_pay[i].size() > 0) ? q_pay[i][0] : '0;
      s_if.hdr_valid[i]            = (q_hdr[i].size() > 0);
      s_if.ip_dest_ip[32*i +: 32]  = h[79:48];
      s_if.source_port[16*i +: 16] = h[47:32];
      s_if.dest_port[16*i +: 16]   = h[31:16];
      s_if.length[16*i +: 16]      = h[15:0];
      s_if.tvalid[i]               = (q_pay[i].size() > 0) && !stall[i];
      s_if.tuser[i]                = p[9];
      s_if.tlast[i]                = p[8];
      s_if.tdata[8*i +: 8]         = p[7:0];
    end
    m_if.hdr_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    m_if.tready    = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Source driver + output monitor/scoreboard: sample at negedge, update at posedge+1.
  initial begin : drv
    logic [N-1:0] hh;
    logic [N-1:0] ph;
    logic [79:0]  hobs;
    logic [9:0]   bobs;
    int           g;
    drive_all();
    forever begin
      @(negedge clk);
      hh = s_if.hdr_valid & s_if.hdr_ready;
      ph = s_if.tvalid & s_if.tready;
      g  = int'(grant);
      if (m_if.hdr_valid[0] && m_if.hdr_ready[0]) begin
        hobs = {m_if.ip_dest_ip, m_if.source_port, m_if.dest_port, m_if.length};
        q_gr.push_back(g);
        q_hcyc.push_back(cyc);
        if (e_hdr[g].size() == 0 || e_hdr[g].pop_front() !== hobs) sb_err++;
      end
      if (m_if.tvalid[0] && m_if.tready[0]) begin
        bobs = {m_if.tuser[0], m_if.tlast[0], m_if.tdata};
        n_beats++;
        if (m_if.tlast[0]) q_lcyc.push_back(cyc);
        if (e_pay[g].size() == 0 || e_pay[g].pop_front() !== bobs) sb_err++;
      end
      if (abort) n_abort++;
      for (int i = 0; i < N; i++)
        if ((s_if.hdr_ready[i] || s_if.tready[i]) && !(busy && g == i)) viol++;
      if (!busy && (m_if.hdr_valid[0] || m_if.tvalid[0])) viol++;
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++) begin
        if (hh[i] && q_hdr[i].size() > 0) void'(q_hdr[i].pop_front());
        if (ph[i] && q_pay[i].size() > 0) void'(q_pay[i].pop_front());
      end
      drive_all();
    end
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: observed still running, expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int r, input logic [79:0] h, input int nb, input logic [7:0] base);
    logic [9:0] p;
    q_hdr[r].push_back(h);
    e_hdr[r].push_back(h);
    for (int b = 0; b < nb; b++) begin
      p = {1'b0, (b == nb - 1), 8'(int'(base) + b)};
      q_pay[r].push_back(p);
      e_pay[r].push_back(p);
    end
  endtask

  task automatic wait_beats(input string tag, input int target, input int limit);
    int k = 0;
    while (n_beats < target && k < limit) begin
      tick();
      k++;
    end
    chk(tag, n_beats >= target, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_abort"}, abort, 0);
    chk({tag, "_mvalid"}, {m_if.hdr_valid, m_if.tvalid}, 0);
    chk({tag, "_mfields"}, {m_if.ip_dest_ip, m_if.source_port, m_if.dest_port, m_if.length}, 0);
    chk({tag, "_mpay"}, {m_if.tdata, m_if.tlast, m_if.tuser}, 0);
    chk({tag, "_sready"}, {s_if.hdr_ready, s_if.tready}, 0);
  endtask

  initial begin
    int k;
    int b0;
    int g0;
    int l0;
    int c0;
    int r;
    int exp3[4] = '{0, 2, 0, 0};
    logic [79:0] h1 = {32'hC0A8010A, 16'd5000, 16'd6000, 16'd12};
    logic [9:0]  p;

    repeat (3) tick();
    chk_quiet("rst");
    reset = 1'b0;
    tick();
    tick();
    chk("idle_busy", busy, 0);

    // Single request on requester 1
    b0 = n_beats;
    push_frame(1, h1, 4, 8'hA0);
    k = 0;
    while (!s_if.hdr_valid[1] && k < 10) begin tick(); k++; end
    chk("t1_req_seen", s_if.hdr_valid[1], 1);
    chk("t1_idle_at_req", busy, 0);
    tick();
    chk("t1_hdr_valid", m_if.hdr_valid, 1);
    chk("t1_grant", grant, 1);
    chk("t1_fields", {m_if.ip_dest_ip, m_if.source_port, m_if.dest_port, m_if.length}, h1);
    wait_beats("t1_beats", b0 + 4, 20);
    tick();
    chk("t1_busy_drop", busy, 0);
    chk("t1_hdr_to_last", q_lcyc[$] - q_hcyc[$], 4);
    chk("t1_sb", sb_err, 0);

    // Four simultaneous requesters after reset: order 0,1,2,3 with one idle cycle
    do_reset();
    g0 = q_gr.size();
    l0 = q_lcyc.size();
    b0 = n_beats;
    for (int i = 0; i < 4; i++)
      push_frame(i, {32'h0A000001 + i, 16'(100 + i), 16'(200 + i), 16'd11}, 3, 8'(16 * (i + 1)));
    wait_beats("t2_beats", b0 + 12, 80);
    tick();
    for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), q_gr[g0 + i], i);
    for (int i = 0; i < 3; i++) chk($sformatf("t2_gap%0d", i), q_hcyc[g0 + i + 1] - q_lcyc[l0 + i], 2);
    chk("t2_sb", sb_err, 0);

    // Requester 0 back-to-back, requester 2 once: 0,2,0,0
    do_reset();
    g0 = q_gr.size();
    b0 = n_beats;
    for (int i = 0; i < 3; i++) push_frame(0, {32'h0B000000 + i, 16'd1, 16'd2, 16'd10}, 2, 8'(8'h40 + 4 * i));
    push_frame(2, {32'h0C000002, 16'd3, 16'd4, 16'd10}, 2, 8'h80);
    wait_beats("t3_beats", b0 + 8, 80);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_grant%0d", i), q_gr[g0 + i], exp3[i]);
    chk("t3_sb", sb_err, 0);

    // 200 random frames from requesters 0,1,3 under 50% downstream backpressure
    g0 = q_gr.size();
    b0 = n_beats;
    c0 = 0;
    bp_rand = 1'b1;
    for (int f = 0; f < 200; f++) begin
      r = $urandom_range(0, 2);
      if (r == 2) r = 3;
      k = $urandom_range(1, 4);
      c0 += k;
      push_frame(r, {32'($urandom), 16'($urandom), 16'($urandom), 16'(8 + k)}, k, 8'($urandom));
    end
    wait_beats("t4_beats", b0 + c0, 20000);
    bp_rand = 1'b0;
    tick();
    tick();
    chk("t4_frames", q_gr.size() - g0, 200);
    chk("t4_sb", sb_err, 0);
    chk("t4_left", e_pay[0].size() + e_pay[1].size() + e_pay[3].size(), 0);
    chk("t4_viol", viol, 0);
    chk("abort_idle", n_abort, 0);

`ifdef UDP_TX_ARB_WATCHDOG_EN
    // Requester 1 stalls after 2 of 6 bytes; errored tail beat, drain, then requester 2
    do_reset();
    b0 = n_beats;
    q_hdr[1].push_back({32'h0D000001, 16'd7, 16'd8, 16'd14});
    e_hdr[1].push_back({32'h0D000001, 16'd7, 16'd8, 16'd14});
    for (int b = 0; b < 6; b++) begin
      p = {1'b0, (b == 5), 8'(8'hD0 + b)};
      q_pay[1].push_back(p);
      if (b < 2) e_pay[1].push_back(p);
    end
    e_pay[1].push_back(10'h300);
    push_frame(2, {32'h0D000002, 16'd9, 16'd10, 16'd10}, 2, 8'hE0);
    while (n_beats < b0 + 2 && k < 40) begin tick(); k++; end
    stall[1] = 1'b1;
    c0 = cyc;
    k = 0;
    while (n_abort < 1 && k < 40) begin tick(); k++; end
    chk("wd_abort", n_abort, 1);
    chk("wd_not_early", (cyc - c0) > TO, 1);
    stall[1] = 1'b0;
    wait_beats("wd_beats", b0 + 5, 60);
    chk("wd_drained", q_pay[1].size(), 0);
    chk("wd_next_grant", q_gr[$], 2);
    chk("wd_sb", sb_err, 0);
`endif

    // Reset during payload beat 3, then a fresh round starts from requester 0
    b0 = n_beats;
    push_frame(2, {32'h0E000002, 16'd11, 16'd12, 16'd14}, 6, 8'h60);
    k = 0;
    while (n_beats < b0 + 2 && k < 40) begin tick(); k++; end
    reset = 1'b1;
    tick();
    chk_quiet("mid_rst");
    q_pay[2].delete();
    e_pay[2].delete();
    reset = 1'b0;
    g0 = q_gr.size();
    b0 = n_beats;
    push_frame(1, {32'h0F000001, 16'd13, 16'd14, 16'd10}, 2, 8'h70);
    push_frame(0, {32'h0F000000, 16'd15, 16'd16, 16'd10}, 2, 8'h78);
    wait_beats("t6_beats", b0 + 4, 40);
    chk("t6_first", q_gr[g0], 0);
    chk("t6_second", q_gr[g0 + 1], 1);
    chk("t6_sb", sb_err, 0);
    chk("final_viol", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
